// File: rtl/demux16_pkg.sv
// Shared constants and state encoding for the 16:1 serial demultiplexer.
// DEMUX16_PARITY_EN adds the PARITY state and lengthens a frame to 17 bits.
package demux16_pkg;

    localparam int unsigned DEMUX_WIDTH = 16;
    localparam int unsigned DEMUX_IDX_W = 4;

`ifdef DEMUX16_PARITY_EN
    localparam int unsigned FRAME_LEN = DEMUX_WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = DEMUX_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef DEMUX16_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

endpackage

// File: rtl/demux16_dec.sv
// Combinational 4-to-16 one-hot decoder driving the shadow-slot write enables;
// the structural inverse of the 16:1 mux tree.
module demux16_dec
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned IDX_W = DEMUX_IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             wr,
    output logic [WIDTH-1:0] en
);

    always_comb begin
        en = '0;
        if (wr) begin
            en[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux16_deser.sv
// Serial-to-parallel demultiplexer: assembles framed bits into a 16-bit word.
// Build option DEMUX16_PARITY_EN appends an even-parity bit and the par_err port.
module demux16_deser
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned IDX_W = DEMUX_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic [IDX_W-1:0] sel,
    output logic             busy,
    output logic             frame_err
`ifdef DEMUX16_PARITY_EN
    ,
    output logic             par_err
`endif
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] wr_idx;
    logic             wr;
    logic [WIDTH-1:0] wr_en;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             load_out;
    logic             abort;

    demux16_dec #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_dec (
        .idx(wr_idx),
        .wr (wr),
        .en (wr_en)
    );

    // A frame_start always lands in slot 0, regardless of the current index.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wr       = 1'b0;
        wr_idx   = sel_q;
        load_out = 1'b0;
        abort    = 1'b0;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        wr      = 1'b1;
                        wr_idx  = '0;
                        sel_d   = ONE;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    wr = 1'b1;
                    if (frame_start) begin
                        abort  = 1'b1;
                        wr_idx = '0;
                        sel_d  = ONE;
                    end else if (sel_q == LAST_SLOT) begin
                        sel_d = '0;
`ifdef DEMUX16_PARITY_EN
                        state_d = PARITY;
`else
                        load_out = 1'b1;
                        state_d  = IDLE;
`endif
                    end else begin
                        sel_d = sel_q + ONE;
                    end
                end
`ifdef DEMUX16_PARITY_EN
                PARITY: begin
                    if (frame_start) begin
                        abort   = 1'b1;
                        wr      = 1'b1;
                        wr_idx  = '0;
                        sel_d   = ONE;
                        state_d = SHIFT;
                    end else begin
                        load_out = 1'b1;
                        state_d  = IDLE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        shadow_d = (shadow_q & ~wr_en) | (wr_en & {WIDTH{in_bit}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            shadow_q  <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            out_valid <= load_out;
            frame_err <= abort;
            // Merge the bit sampled on this edge so completion has no extra cycle.
            if (load_out) begin
                out_word <= shadow_d;
            end
        end
    end

`ifdef DEMUX16_PARITY_EN
    logic par_acc;

    // Slot 0 is only written at frame start, so it restarts the running XOR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_acc <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (wr) begin
                par_acc <= (wr_idx == '0) ? in_bit : (par_acc ^ in_bit);
            end
            if (load_out) begin
                par_err <= par_acc ^ in_bit;
            end
        end
    end
`endif

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_demux16_deser.sv
// Scoreboard bench for demux16_deser: frame-level reference model plus a
// negedge monitor. Honours DEMUX16_PARITY_EN when defined.
module tb_demux16_deser;
    import demux16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] out_word;
    logic        out_valid;
    logic [3:0]  sel;
    logic        busy;
    logic        frame_err;
`ifdef DEMUX16_PARITY_EN
    logic        par_err;
`endif

    demux16_deser #(
        .WIDTH(16),
        .IDX_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .frame_start(frame_start),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .sel        (sel),
        .busy       (busy),
        .frame_err  (frame_err)
`ifdef DEMUX16_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic        p;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          ferr_q[$];
    logic        fbits[$];
    logic [15:0] model_word = '0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is simply the list of valid bits since frame_start.
    task automatic model(input logic v, input logic b, input logic fs);
        logic [15:0] w;
        logic        p;
        if (!v) return;
        if (fs) begin
            if (fbits.size() > 0) ferr_q.push_back(cyc);
            fbits.delete();
            fbits.push_back(b);
        end else if (fbits.size() > 0) begin
            fbits.push_back(b);
        end
        if (fbits.size() == int'(FRAME_LEN)) begin
            w = '0;
            p = 1'b0;
            for (int k = 0; k < 16; k++) w[k] = fbits[k];
            foreach (fbits[k]) p = p ^ fbits[k];
            sb.push_back('{w: w, p: p, c: cyc});
            model_word = w;
            fbits.delete();
        end
    endtask

    task automatic send(input logic v, input logic b, input logic fs);
        in_valid    = v;
        in_bit      = b;
        frame_start = fs;
        @(posedge clk);
        model(v, b, fs);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic gaps(input int pct);
        int n = 0;
        while (($urandom_range(0, 99) < pct) && (n < 8)) begin
            send(1'b0, 1'($urandom), 1'($urandom));
            n++;
        end
    endtask

    task automatic send_data(input logic [15:0] w, input int gap_pct);
        for (int k = 0; k < 16; k++) begin
            if (k != 0) gaps(gap_pct);
            send(1'b1, w[k], k == 0);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap_pct);
        send_data(w, gap_pct);
`ifdef DEMUX16_PARITY_EN
        gaps(gap_pct);
        send(1'b1, ^w, 1'b0);
`endif
    endtask

`ifdef DEMUX16_PARITY_EN
    task automatic send_frame_p(input logic [15:0] w, input logic pbit);
        send_data(w, 0);
        send(1'b1, pbit, 1'b0);
    endtask
`endif

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) send(1'b1, 1'($urandom), k == 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        fbits.delete();
        model_word = '0;
        mon_en     = 1'b1;
        #1;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic exp_ov;
        logic exp_fe;
        exp_t e;
        if (mon_en) begin
            exp_ov = (sb.size() > 0) && (sb[0].c == cyc);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                e = sb.pop_front();
                check("out_word_new", 32'(out_word), 32'(e.w));
`ifdef DEMUX16_PARITY_EN
                check("par_err", 32'(par_err), 32'(e.p));
`endif
            end
            exp_fe = (ferr_q.size() > 0) && (ferr_q[0] == cyc);
            check("frame_err", 32'(frame_err), 32'(exp_fe));
            if (exp_fe) void'(ferr_q.pop_front());
            check("sel", 32'(sel), 32'(fbits.size() % 16));
            check("busy", 32'(busy), 32'(fbits.size() > 0));
            check("out_word_hold", 32'(out_word), 32'(model_word));
        end
        cyc++;
    end

    initial begin
        do_reset();
        idle(2);

        send_frame(16'hA5C3, 0);
        idle(3);

        send_frame(16'hFFFF, 0);
        send_frame(16'h0001, 40);
        idle(2);

        for (int k = 0; k < 6; k++) send(1'b1, 1'($urandom), 1'b0);
        idle(1);

        send_partial(9);
        send_frame(16'h1234, 0);
        idle(2);

        send_partial(7);
        do_reset();
        send_frame(16'h8001, 0);
        idle(2);

`ifdef DEMUX16_PARITY_EN
        send_frame_p(16'h0003, 1'b0);
        idle(1);
        send_frame_p(16'h0007, 1'b0);
        idle(1);
        send_partial(16);
        send_frame(16'h5A5A, 0);
        idle(1);
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: for (int k = 0; k < 3; k++) send(1'b1, 1'($urandom), 1'b0);
                1: send_partial($urandom_range(1, 15));
                2: idle($urandom_range(1, 3));
`ifdef DEMUX16_PARITY_EN
                3: send_frame_p(16'($urandom), 1'($urandom));
`endif
                default: send_frame(16'($urandom), $urandom_range(0, 30));
            endcase
        end
        send_frame(16'($urandom), 0);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("frame_err_drained", 32'(ferr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
